// File: rtl/dcache_refill_engine.sv
// rtl/dcache_refill_engine.sv - line-fill and dirty-victim write-back engine for the data cache
// Optional build macro: CRITICAL_WORD_FIRST_EN (fill starts at the missing word and wraps).
module dcache_refill_engine #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_req,
  input  logic [ADDR_WIDTH-1:0]           miss_addr,
  input  logic                            wb_req,
  input  logic [ADDR_WIDTH-1:0]           wb_addr,
  input  logic [WIDTH*WORDS_PER_LINE-1:0] wb_line,
  output logic                            busy,
  output logic                            refill_valid,
  output logic [WIDTH*WORDS_PER_LINE-1:0] refill_line,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [WIDTH-1:0]                mem_wdata,
  input  logic [WIDTH-1:0]                mem_rdata,
  input  logic                            mem_ack
);

  localparam int IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int BYTE_W     = $clog2(WIDTH / 8);
  localparam int LINE_BYTES = WORDS_PER_LINE * (WIDTH / 8);

  // Byte-offset-within-line mask; the line base is the address with these bits cleared.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                      state;
  logic [IDX_W-1:0]                idx;         // word currently presented on the memory port
  logic [IDX_W-1:0]                cnt;         // words completed in the current phase
  logic [IDX_W-1:0]                fill_start;  // first fill word, latched at accept
  logic [ADDR_WIDTH-1:0]           fill_base;
  logic [ADDR_WIDTH-1:0]           wb_base;
  logic [WIDTH*WORDS_PER_LINE-1:0] wb_data;

  logic [IDX_W-1:0] miss_start;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] next_cnt;
  logic             xfer;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_addr[IDX_W+BYTE_W-1:BYTE_W];
`else
  assign miss_start = '0;
`endif

  assign next_idx = idx + 1'b1;
  assign next_cnt = cnt + 1'b1;
  assign xfer     = mem_req & mem_ack;
  assign busy     = miss_req | (state != S_IDLE);

  // Word-aligned byte address of word i inside the line containing base.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [IDX_W-1:0]      i);
    return (base & ~OFF_MASK) + (ADDR_WIDTH'(i) << BYTE_W);
  endfunction

  // Word i of a packed line.
  function automatic logic [WIDTH-1:0] word_of(input logic [WIDTH*WORDS_PER_LINE-1:0] line,
                                               input logic [IDX_W-1:0]                i);
    return line[int'(i)*WIDTH +: WIDTH];
  endfunction

  // Sequencer: accept a miss, stream the victim out, stream the new line in, pulse completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      fill_start   <= '0;
      fill_base    <= '0;
      wb_base      <= '0;
      wb_data      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      refill_valid <= 1'b0;
      refill_line  <= '0;
    end else begin
      refill_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_req) begin
            fill_base  <= miss_addr & ~OFF_MASK;
            fill_start <= miss_start;
            wb_base    <= wb_addr & ~OFF_MASK;
            wb_data    <= wb_line;
            cnt        <= '0;
            mem_req    <= 1'b1;
            if (wb_req) begin
              state     <= S_WB;
              idx       <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= word_addr(wb_addr, '0);
              mem_wdata <= word_of(wb_line, '0);
            end else begin
              state    <= S_FILL;
              idx      <= miss_start;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(miss_addr, miss_start);
            end
          end
        end
        S_WB: begin
          if (xfer) begin
            if (cnt == LAST_IDX) begin
              // Victim fully written; the request stays up and turns into the first fill read.
              state    <= S_FILL;
              cnt      <= '0;
              idx      <= fill_start;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(fill_base, fill_start);
            end else begin
              cnt       <= next_cnt;
              idx       <= next_idx;
              mem_addr  <= word_addr(wb_base, next_idx);
              mem_wdata <= word_of(wb_data, next_idx);
            end
          end
        end
        S_FILL: begin
          if (xfer) begin
            refill_line[int'(idx)*WIDTH +: WIDTH] <= mem_rdata;
            if (cnt == LAST_IDX) begin
              state        <= S_DONE;
              cnt          <= '0;
              mem_req      <= 1'b0;
              refill_valid <= 1'b1;
            end else begin
              cnt      <= next_cnt;
              idx      <= next_idx;
              mem_addr <= word_addr(fill_base, next_idx);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// tb/tb_dcache_refill_engine.sv - directed and randomized checks of dcache_refill_engine against a line-level model
module tb_dcache_refill_engine;

  localparam int W  = 32;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam int LW = W * N;
  localparam int LINE_BYTES = N * W / 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [AW-1:0] miss_addr;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic [LW-1:0] wb_line;
  logic          busy;
  logic          refill_valid;
  logic [LW-1:0] refill_line;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ack;

  int            n_vec = 0;
  int            n_err = 0;
  int            wait_n = 0;
  int            exp_lat = 0;
  logic [AW-1:0] salt = '0;
  logic [LW-1:0] exp_line = '0;
  xfer_t         log_q[$];
  xfer_t         exp_q[$];
  bit            cwf;

  dcache_refill_engine #(.WIDTH(W), .ADDR_WIDTH(AW), .WORDS_PER_LINE(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .wb_req       (wb_req),
    .wb_addr      (wb_addr),
    .wb_line      (wb_line),
    .busy         (busy),
    .refill_valid (refill_valid),
    .refill_line  (refill_line),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ salt;
  endfunction

  // Backing memory: answers after wait_n idle cycles, logs every completed transfer,
  // and throws random acks at the engine while it is not requesting.
  initial begin
    xfer_t prev;
    xfer_t t;
    bit    pending;
    int    wc;
    pending   = 0;
    wc        = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        t.we   = mem_we;
        t.addr = mem_addr;
        t.data = mem_wdata;
        if (pending) check("hold_stable", t, prev);
        if (wc >= wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          if (!mem_we) t.data = '0;
          log_q.push_back(t);
          wc      = 0;
          pending = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          prev      = t;
          wc++;
          pending   = 1;
        end
      end else begin
        mem_ack   = 1'(($urandom_range(0, 1)));
        mem_rdata = $urandom;
        wc        = 0;
        pending   = 0;
      end
    end
  end

  // Builds the expected transfer list and line, then presents the miss (call at a negedge).
  task automatic start_miss(input logic [AW-1:0] addr, input logic wb,
                            input logic [AW-1:0] wba, input logic [LW-1:0] wbl);
    logic [AW-1:0] fb;
    logic [AW-1:0] wbb;
    int            st;
    xfer_t         t;
    fb = (addr / LINE_BYTES) * LINE_BYTES;
    st = cwf ? int'((addr % LINE_BYTES) / (W / 8)) : 0;
    exp_q.delete();
    log_q.delete();
    if (wb) begin
      wbb = (wba / LINE_BYTES) * LINE_BYTES;
      for (int i = 0; i < N; i++) begin
        t.we   = 1'b1;
        t.addr = wbb + AW'(i * (W / 8));
        t.data = wbl[i*W +: W];
        exp_q.push_back(t);
      end
    end
    for (int i = 0; i < N; i++) begin
      int j;
      j      = (st + i) % N;
      t.we   = 1'b0;
      t.addr = fb + AW'(j * (W / 8));
      t.data = '0;
      exp_q.push_back(t);
      exp_line[j*W +: W] = mem_word(t.addr);
    end
    exp_lat   = (wb ? 2 * N : N) * (wait_n + 1) + 1;
    miss_addr = addr;
    wb_req    = wb;
    wb_addr   = wba;
    wb_line   = wbl;
    miss_req  = 1'b1;
  endtask

  // Waits (bounded) for the refill pulse and compares latency, transfers and line.
  task automatic finish_miss(input string name, input bit keep);
    int k;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (refill_valid === 1'b1) break;
      check({name, " busy"}, busy, 1);
    end
    check({name, " latency"}, k, exp_lat);
    check({name, " line"}, refill_line, exp_line);
    check({name, " mem_req_done"}, mem_req, 0);
    check({name, " xfer_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s xfer%0d", name, i), log_q[i], exp_q[i]);
    if (!keep) begin
      miss_req = 1'b0;
      wb_req   = 1'b0;
      @(negedge clk);
      check({name, " single_pulse"}, refill_valid, 0);
      check({name, " idle_busy"}, busy, 0);
      check({name, " line_hold"}, refill_line, exp_line);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [LW-1:0] l;
`ifdef CRITICAL_WORD_FIRST_EN
    cwf = 1'b1;
`else
    cwf = 1'b0;
`endif
    rst       = 1'b0;
    miss_req  = 1'b0;
    miss_addr = '0;
    wb_req    = 1'b0;
    wb_addr   = '0;
    wb_line   = '0;

    repeat (2) @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst refill_valid", refill_valid, 0);
    check("rst refill_line", refill_line, 0);
    check("rst busy", busy, 0);
    miss_req = 1'b1;
    #1 check("rst busy_follows_miss", busy, 1);
    miss_req = 1'b0;
    #1 check("rst busy_drop", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Plain fill, memory word = address.
    salt = '0; wait_n = 0;
    start_miss(32'h104, 1'b0, '0, '0);
    finish_miss("plain", 0);

    // Dirty victim written back before the fill.
    salt = 32'h5A5A_0000;
    start_miss(32'h300, 1'b1, 32'h200,
               {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    finish_miss("dirty", 0);

    // Two wait cycles per ack.
    wait_n = 2;
    start_miss(32'h104, 1'b0, '0, '0);
    finish_miss("wait2", 0);

    // Miss in the middle of the line (critical-word order when enabled).
    wait_n = 0; salt = '0;
    start_miss(32'h108, 1'b0, '0, '0);
    finish_miss("mid_word", 0);

    // Reset while the second fill word is on the bus.
    salt = $urandom;
    start_miss(32'h500, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("abort second_word", mem_addr, exp_q[1].addr);
    #2 rst = 1'b0;
    miss_req = 1'b0;
    #1;
    check("abort mem_req", mem_req, 0);
    check("abort refill_valid", refill_valid, 0);
    check("abort refill_line", refill_line, 0);
    check("abort busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort no_pulse", refill_valid, 0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort idle_req", mem_req, 0);
      check("abort idle_pulse", refill_valid, 0);
    end
    start_miss($urandom, 1'b0, '0, '0);
    finish_miss("after_abort", 0);

    // miss_req held through DONE with a new address.
    salt = $urandom;
    start_miss($urandom, 1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom});
    finish_miss("held_first", 1);
    miss_addr = 32'h400;
    wb_req    = 1'b0;
    @(negedge clk);
    check("held no_accept_in_done", mem_req, 0);
    check("held no_second_pulse", refill_valid, 0);
    check("held busy", busy, 1);
    start_miss(32'h400, 1'b0, '0, '0);
    finish_miss("held_second", 0);

    // Randomized misses against the line model.
    for (int r = 0; r < 12; r++) begin
      salt   = $urandom;
      wait_n = $urandom_range(0, 3);
      a      = $urandom;
      b      = $urandom;
      l      = {$urandom, $urandom, $urandom, $urandom};
      start_miss(a, 1'($urandom_range(0, 1)), b, l);
      finish_miss($sformatf("rand%0d", r), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
